// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package dmem_pkg;

  // FSM states of dmem_lsu
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } lsu_state_t;

  // AXI response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Bus accesses are always word aligned
  localparam logic [31:0] DMEM_ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: turns one MEM-stage request into a single-beat
// AXI4-Lite read or write and holds the completion until the MEM stage advances.
// Optional feature macro: DMEM_LSU_RESP_CHECK_EN adds sticky bus_err/err_addr
// reporting of non-OKAY read/write responses.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for a request, latches address/mask/data
// ST_RD_ADDR | arvalid high until arready
// ST_RD_DATA | rready high until rvalid, read word captured
// ST_WR      | awvalid/wvalid high, each dropped on its own handshake
// ST_WR_RESP | bready high until bvalid
// ST_DONE    | d_rready/d_wready held until req_ack
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  dram_en,
  input  logic                  dram_wen,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   wmask,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  req_ack,
  output logic                  d_rready,
  output logic                  d_wready,
  output logic [DATA_W-1:0]     d_rdata,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
`ifdef DMEM_LSU_RESP_CHECK_EN
  ,
  output logic                  bus_err,
  output logic [ADDR_W-1:0]     err_addr
`endif
);

  lsu_state_t            r_state;
  lsu_state_t            w_state_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W/8-1:0]   r_wmask;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_is_wr;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [DATA_W-1:0]     r_rdata;
  logic [ADDR_W-1:0]     w_bus_addr;
  logic                  w_aw_hs;
  logic                  w_w_hs;

  assign w_bus_addr = {r_addr[ADDR_W-1:2], r_addr[1:0] & DMEM_ADDR_ALIGN_MASK[1:0]};
  assign w_aw_hs    = awvalid & awready;
  assign w_w_hs     = wvalid & wready;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a write leaves WR once both channels have handshaken
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (dram_wen)     w_state_nxt = ST_WR;
        else if (dram_en) w_state_nxt = ST_RD_ADDR;
      end
      ST_RD_ADDR: if (arready) w_state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (rvalid)  w_state_nxt = ST_DONE;
      ST_WR: begin
        if ((r_aw_done | awready) & (r_w_done | wready)) w_state_nxt = ST_WR_RESP;
      end
      ST_WR_RESP: if (bvalid)  w_state_nxt = ST_DONE;
      ST_DONE:    if (req_ack) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore output decode from registered state and channel flags only
  always_comb begin
    arvalid  = (r_state == ST_RD_ADDR);
    rready   = (r_state == ST_RD_DATA);
    awvalid  = (r_state == ST_WR) & ~r_aw_done;
    wvalid   = (r_state == ST_WR) & ~r_w_done;
    bready   = (r_state == ST_WR_RESP);
    d_rready = (r_state == ST_DONE) & ~r_is_wr;
    d_wready = (r_state == ST_DONE) & r_is_wr;
    araddr   = w_bus_addr;
    awaddr   = w_bus_addr;
    wdata_o  = r_wdata;
    wstrb    = r_wmask;
    d_rdata  = r_rdata;
  end

  // Request latch: only loaded in IDLE, so bus fields stay stable while any valid is high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wmask <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (dram_wen) begin
        r_addr  <= addr;
        r_wmask <= wmask;
        r_wdata <= wdata;
        r_is_wr <= 1'b1;
      end else if (dram_en) begin
        r_addr  <= addr;
        r_is_wr <= 1'b0;
      end
    end
  end

  // Write-channel completion flags, cleared while idle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state == ST_WR) begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  // Read word capture; held until the next read beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                             r_rdata <= '0;
    else if ((r_state == ST_RD_DATA) && rvalid) r_rdata <= rdata;
  end

`ifdef DMEM_LSU_RESP_CHECK_EN
  logic              r_bus_err;
  logic [ADDR_W-1:0] r_err_addr;
  logic              w_resp_err;

  assign w_resp_err = ((r_state == ST_RD_DATA) & rvalid & (rresp != OKAY)) |
                      ((r_state == ST_WR_RESP) & bvalid & (bresp != OKAY));

  // Sticky error flag; the first failing access address is kept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
    end else if (w_resp_err && !r_bus_err) begin
      r_bus_err  <= 1'b1;
      r_err_addr <= r_addr;
    end
  end

  assign bus_err  = r_bus_err;
  assign err_addr = r_err_addr;
`else
  logic w_unused_resp;
  assign w_unused_resp = ^{rresp, bresp};
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
`timescale 1ns/1ps
module tb_dmem_lsu;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        dram_en = 1'b0, dram_wen = 1'b0, req_ack = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wmask = '0;
  logic        d_rready, d_wready;
  logic [31:0] d_rdata;
  logic [31:0] araddr, awaddr, wdata_o;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [3:0]  wstrb;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;
`ifdef DMEM_LSU_RESP_CHECK_EN
  logic        bus_err;
  logic [31:0] err_addr;
`endif

  dmem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .dram_en(dram_en), .dram_wen(dram_wen),
    .addr(addr), .wmask(wmask), .wdata(wdata), .req_ack(req_ack),
    .d_rready(d_rready), .d_wready(d_wready), .d_rdata(d_rdata),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata_o(wdata_o), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef DMEM_LSU_RESP_CHECK_EN
    , .bus_err(bus_err), .err_addr(err_addr)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference model: a word-addressed memory updated with byte strobes
  logic [31:0] ref_mem [64];
  logic [31:0] slv_mem [64];

  typedef struct packed {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  logic        exp_bus_err = 1'b0;
  logic [31:0] exp_err_addr = '0;

  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic [3:0]  cur_strb = '0;
  logic [1:0]  cur_resp = '0;
  int dly_ar = 0, dly_aw = 0, dly_w = 0, dly_r = 0, dly_b = 0;
  bit rand_dly = 1'b0;

  function automatic int pick(input int d);
    return rand_dly ? int'($urandom_range(0, 3)) : d;
  endfunction

  // AXI4-Lite slave: decisions made at negedge, handshakes land on the next posedge
  initial begin : slave
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    bit ar_c, aw_c, w_c, r_c, b_c, r_pend, b_pend, aw_got, w_got;
    logic [31:0] ar_a, aw_a, w_d;
    logic [3:0]  w_s;
    ar_cnt = -1; aw_cnt = -1; w_cnt = -1; r_cnt = 0; b_cnt = 0;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0; r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    ar_a = '0; aw_a = '0; w_d = '0; w_s = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        ar_cnt = -1; aw_cnt = -1; w_cnt = -1;
        ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0; r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        continue;
      end
      if (ar_c) begin arready = 0; ar_c = 0; end
      if (aw_c) begin awready = 0; aw_c = 0; end
      if (w_c)  begin wready = 0;  w_c = 0;  end
      if (r_c)  begin rvalid = 0;  r_c = 0;  end
      if (b_c)  begin bvalid = 0;  b_c = 0;  end
      if (r_pend && !rvalid) begin
        if (r_cnt > 0) r_cnt--;
        else begin rvalid = 1; rdata = slv_mem[ar_a[7:2]]; rresp = cur_resp; end
      end
      if (rvalid && rready) begin r_c = 1; r_pend = 0; end
      if (b_pend && !bvalid) begin
        if (b_cnt > 0) b_cnt--;
        else begin bvalid = 1; bresp = cur_resp; end
      end
      if (bvalid && bready) begin b_c = 1; b_pend = 0; end
      if (arvalid) begin
        if (ar_cnt < 0) ar_cnt = pick(dly_ar);
        if (ar_cnt == 0) begin
          arready = 1; ar_c = 1; ar_cnt = -1;
          chk("araddr", araddr, cur_addr & 32'hFFFF_FFFC);
          ar_a = araddr; r_pend = 1; r_cnt = pick(dly_r);
        end else ar_cnt--;
      end
      if (awvalid) begin
        if (aw_cnt < 0) aw_cnt = pick(dly_aw);
        if (aw_cnt == 0) begin
          awready = 1; aw_c = 1; aw_cnt = -1; aw_got = 1; aw_a = awaddr;
          chk("awaddr", awaddr, cur_addr & 32'hFFFF_FFFC);
        end else aw_cnt--;
      end
      if (wvalid) begin
        if (w_cnt < 0) w_cnt = pick(dly_w);
        if (w_cnt == 0) begin
          wready = 1; w_c = 1; w_cnt = -1; w_got = 1; w_d = wdata_o; w_s = wstrb;
          chk("wstrb", 32'(wstrb), 32'(cur_strb));
          chk("wdata_o", wdata_o, cur_wdata);
        end else w_cnt--;
      end
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) slv_mem[aw_a[7:2]][8*b +: 8] = w_d[8*b +: 8];
        b_pend = 1; b_cnt = pick(dly_b); aw_got = 0; w_got = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each new completion
  initial begin : monitor
    bit   prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin prev = 0; continue; end
      if ((d_rready || d_wready) && !prev) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got completion, expected none");
        end else begin
          e = sb_q.pop_front();
          chk("done_kind", 32'(d_wready), 32'(e.is_wr));
          chk("done_excl", 32'(d_rready & d_wready), 32'd0);
          if (!e.is_wr) chk("d_rdata", d_rdata, e.rdata);
`ifdef DMEM_LSU_RESP_CHECK_EN
          if (e.err && !exp_bus_err) begin exp_bus_err = 1; exp_err_addr = e.addr; end
          chk("bus_err", 32'(bus_err), 32'(exp_bus_err));
          chk("err_addr", err_addr, exp_err_addr);
`endif
        end
      end
      prev = d_rready || d_wready;
    end
  end

  int lat, ar_first, rr_first, b_first, aw_cycles, w_cycles;

  task automatic access(input bit is_wr, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, input logic [1:0] resp, input int hold);
    exp_t e;
    int k;
    logic [31:0] snap;
    cur_addr = a; cur_strb = m; cur_wdata = d; cur_resp = resp;
    e.is_wr = is_wr; e.addr = a; e.err = (resp != 2'b00); e.rdata = ref_mem[a[7:2]];
    if (is_wr)
      for (int b = 0; b < 4; b++)
        if (m[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
    sb_q.push_back(e);
    @(negedge clock);
    dram_en = 1; dram_wen = is_wr; addr = a; wmask = m; wdata = d;
    @(posedge clock);
    k = 0; lat = -1; ar_first = -1; rr_first = -1; b_first = -1; aw_cycles = 0; w_cycles = 0;
    while (k < 200) begin
      @(negedge clock);
      k++;
      if (arvalid && ar_first < 0) ar_first = k;
      if (rready && rr_first < 0)  rr_first = k;
      if (bready && b_first < 0)   b_first = k;
      if (awvalid) aw_cycles++;
      if (wvalid)  w_cycles++;
      if (d_rready || d_wready) begin
        lat = k; dram_en = 0; dram_wen = 0; req_ack = 0;
        break;
      end
      // noise on the request side is ignored outside IDLE/DONE
      dram_en = 1'($urandom); dram_wen = 1'($urandom); req_ack = 1'($urandom);
      addr = $urandom; wdata = $urandom; wmask = 4'($urandom);
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL timeout: got no completion in 200 cycles, expected one");
      dram_en = 0; dram_wen = 0; req_ack = 0;
      return;
    end
    snap = d_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_ready", 32'(d_rready | d_wready), 32'd1);
      chk("hold_rdata", d_rdata, snap);
    end
    req_ack = 1;
    @(negedge clock);
    req_ack = 0;
    chk("ack_idle", 32'(d_rready | d_wready), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] v, a, hi;
    int k;
    bit seen;
    for (int i = 0; i < 64; i++) begin v = $urandom; ref_mem[i] = v; slv_mem[i] = v; end
    ref_mem[1] = 32'hDEAD_BEEF; slv_mem[1] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_arvalid", 32'(arvalid), 0); chk("rst_rready", 32'(rready), 0);
    chk("rst_awvalid", 32'(awvalid), 0); chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_bready", 32'(bready), 0);   chk("rst_done", 32'(d_rready | d_wready), 0);
    chk("rst_rdata", d_rdata, 0);
`ifdef DMEM_LSU_RESP_CHECK_EN
    chk("rst_bus_err", 32'(bus_err), 0); chk("rst_err_addr", err_addr, 0);
`endif
    reset_n = 1;
    repeat (2) @(negedge clock);

    // zero-wait load
    access(0, 32'h8000_0006, 4'h0, 32'h0, 2'b00, 0);
    chk("ld_arvalid_cyc", 32'(ar_first), 1);
    chk("ld_rready_cyc", 32'(rr_first), 2);
    chk("ld_done_cyc", 32'(lat), 3);
    chk("ld_rdata_held", d_rdata, 32'hDEAD_BEEF);

    // zero-wait store
    access(1, 32'h8000_0048, 4'b0011, 32'h0000_5A5A, 2'b00, 0);
    chk("st0_valid_cyc", 32'(aw_cycles + w_cycles), 2);
    chk("st0_bready_cyc", 32'(b_first), 2);
    chk("st0_done_cyc", 32'(lat), 3);

    // store with awready two cycles late
    dly_aw = 2;
    access(1, 32'h8000_0020, 4'b1100, 32'h1234_0000, 2'b00, 0);
    dly_aw = 0;
    chk("st_awvalid_cycles", 32'(aw_cycles), 3);
    chk("st_wvalid_cycles", 32'(w_cycles), 1);
    chk("st_bready_cyc", 32'(b_first), 4);
    chk("st_done_cyc", 32'(lat), 5);

    // completion held across backpressure
    access(0, 32'h8000_0020, 4'h0, 32'h0, 2'b00, 5);
    chk("bp_rdata", d_rdata, ref_mem[8]);

    // reset while in RD_DATA
    dly_r = 6;
    cur_addr = 32'h8000_0004; cur_resp = 2'b00;
    @(negedge clock);
    dram_en = 1; dram_wen = 0; addr = 32'h8000_0004;
    @(negedge clock);
    dram_en = 0;
    seen = 0;
    for (k = 0; k < 20; k++) begin
      if (rready) begin seen = 1; break; end
      @(negedge clock);
    end
    chk("rst_mid_reached", 32'(seen), 1);
    #2 reset_n = 0;
    #1;
    chk("rstm_arvalid", 32'(arvalid), 0); chk("rstm_rready", 32'(rready), 0);
    chk("rstm_awvalid", 32'(awvalid), 0); chk("rstm_wvalid", 32'(wvalid), 0);
    chk("rstm_bready", 32'(bready), 0);   chk("rstm_done", 32'(d_rready | d_wready), 0);
    chk("rstm_rdata", d_rdata, 0);
    exp_bus_err = 0; exp_err_addr = 0;
    repeat (2) @(negedge clock);
    #2 reset_n = 1;
    dly_r = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("rstm_no_done", 32'(d_rready | d_wready), 0);
    end

    // store answered with SLVERR
    access(1, 32'h0000_0010, 4'hF, 32'hCAFE_0001, 2'b10, 0);
    chk("err_store_done", 32'(lat > 0), 1);
`ifdef DMEM_LSU_RESP_CHECK_EN
    chk("err_bus_err", 32'(bus_err), 1);
    chk("err_addr_val", err_addr, 32'h0000_0010);
`endif

    // randomized traffic
    rand_dly = 1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 2))
        0: hi = 32'h8000_0000;
        1: hi = 32'h0000_0000;
        default: hi = $urandom & 32'hFFFF_FF00;
      endcase
      a = hi | 32'($urandom_range(0, 255));
      access(1'($urandom), a, 4'($urandom), $urandom,
             ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00, $urandom_range(0, 3));
    end
    rand_dly = 0;

    repeat (5) @(negedge clock);
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
